// File: rtl/ifetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ifetch_pkg : shared types and constants for the fetch controller
// Rev 1.0
// ------------------------------------------------------------------
package ifetch_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_buf : DEPTH-entry FIFO of tagged instructions, flush wins
// Rev 1.0
// ------------------------------------------------------------------
module fetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty;
  logic            full;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The issue credit guarantees a push into a full buffer always pairs with a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// ifetch_ctrl : sequences the L1 I-ROM and feeds decode via valid/ready
// Rev 1.0
// ------------------------------------------------------------------
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_re,
  output logic [31:0] mem_a,
  input  logic [31:0] mem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic          misalign_q, misalign_d;

  entry_t        head;
  entry_t        resp;
  logic [CW-1:0] occ;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          resp_kill;
  logic          buf_push;
  logic          buf_pop;
  logic          redirect_aligned;

  // Credit counts only registered state, so out_ready never reaches mem_re.
  assign credit_used      = {1'b0, occ} + (CW+1)'(inflight_q);
  assign issue            = (state_q == ST_RUN) && (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  assign resp_kill = redirect_valid;
  assign buf_push  = inflight_q && !resp_kill;
  assign buf_pop   = out_valid && out_ready && !redirect_valid;
  assign resp.pc    = tag_q;
  assign resp.instr = mem_rd;

  assign mem_re       = issue && rst_n;
  assign mem_a        = {fetch_pc_q[31:2], 2'b00};
  assign out_valid    = (occ != '0) && (state_q == ST_RUN);
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign misalign_err = misalign_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    misalign_d = 1'b0;
    if (redirect_valid) begin
      if (!redirect_aligned) begin
        misalign_d = (state_q == ST_RUN);
        state_d    = ST_FAULT;
        fetch_pc_d = redirect_pc;
      end else begin
        state_d    = ST_RUN;
        fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
      tag_d      = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_fetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data (resp),
    .pop       (buf_pop),
    .head      (head),
    .count     (occ)
  );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ifetch_ctrl : scoreboard bench for the fetch controller
// Rev 1.0
// ------------------------------------------------------------------
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_re;
  logic [31:0] mem_a;
  logic [31:0] mem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  int n_total = 0;
  int n_bad   = 0;

  entry_t      sb_q[$];
  logic [31:0] m_pc;
  logic        m_fault;

  ifetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_re         (mem_re),
    .mem_a          (mem_a),
    .mem_rd         (mem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word k holds value k, one cycle read latency.
  initial mem_rd = '0;
  always @(posedge clk) begin
    if (mem_re) mem_rd <= mem_a >> 2;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    entry_t e;
    if (!rst_n) begin
      sb_q.delete();
      m_pc    = 32'h0000_0000;
      m_fault = 1'b0;
      check_eq("rst_mem_re", 32'(mem_re), 32'd0);
    end else if (redirect_valid) begin
      check_eq("redir_no_issue", 32'(mem_re), 32'd0);
      sb_q.delete();
      if (redirect_pc[1:0] != 2'b00) begin
        m_fault = 1'b1;
      end else begin
        m_fault = 1'b0;
        m_pc    = {redirect_pc[31:2], 2'b00};
      end
    end else begin
      if (m_fault) begin
        check_eq("fault_mem_re", 32'(mem_re), 32'd0);
        check_eq("fault_out_valid", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          check_eq("sb_pc", out_pc, sb_q[0].pc);
          check_eq("sb_instr", out_instr, sb_q[0].instr);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (mem_re) begin
        check_eq("issue_addr", mem_a, m_pc);
        e.pc    = m_pc;
        e.instr = m_pc >> 2;
        sb_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    check_eq("rst_re", 32'(mem_re), 32'd0);
    check_eq("rst_a", mem_a, 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_instr", out_instr, 32'h0);
    check_eq("rst_pc", out_pc, 32'h0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);

    // Streaming from reset, then redirect while 0x10 is in flight (cycle 5).
    next_cycle(); rst_n = 1'b1;                                   // c0
    @(negedge clk);
    check_eq("c0_re", 32'(mem_re), 32'd1);
    check_eq("c0_a", mem_a, 32'h0);
    check_eq("c0_valid", 32'(out_valid), 32'd0);
    next_cycle(); @(negedge clk);                                 // c1
    check_eq("c1_valid", 32'(out_valid), 32'd0);
    next_cycle(); @(negedge clk);                                 // c2
    check_eq("c2_valid", 32'(out_valid), 32'd1);
    check_eq("c2_pc", out_pc, 32'h0);
    check_eq("c2_instr", out_instr, 32'h0);
    next_cycle(); @(negedge clk);                                 // c3
    check_eq("c3_pc", out_pc, 32'h4);
    check_eq("c3_instr", out_instr, 32'h1);
    next_cycle();                                                 // c4
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h100;   // c5
    @(negedge clk);
    check_eq("rd_c5_re", 32'(mem_re), 32'd0);
    next_cycle(); redirect_valid = 1'b0;                          // c6
    @(negedge clk);
    check_eq("rd_c6_valid", 32'(out_valid), 32'd0);
    check_eq("rd_c6_re", 32'(mem_re), 32'd1);
    check_eq("rd_c6_a", mem_a, 32'h100);
    next_cycle(); @(negedge clk);                                 // c7
    check_eq("rd_c7_valid", 32'(out_valid), 32'd0);
    next_cycle(); @(negedge clk);                                 // c8
    check_eq("rd_c8_valid", 32'(out_valid), 32'd1);
    check_eq("rd_c8_pc", out_pc, 32'h100);
    check_eq("rd_c8_instr", out_instr, 32'h40);

    // Misaligned redirect: fault for 10 cycles, then recover at 0x200.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h102;
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("mis_pulse", 32'(misalign_err), 32'd1);
    check_eq("mis_re", 32'(mem_re), 32'd0);
    check_eq("mis_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      next_cycle(); @(negedge clk);
      check_eq("mis_pulse_once", 32'(misalign_err), 32'd0);
      check_eq("mis_hold_re", 32'(mem_re), 32'd0);
    end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("rec_re", 32'(mem_re), 32'd1);
    check_eq("rec_a", mem_a, 32'h200);
    next_cycle(); next_cycle(); @(negedge clk);
    check_eq("rec_valid", 32'(out_valid), 32'd1);
    check_eq("rec_pc", out_pc, 32'h200);

    // Mid-stream reset with a fetch in flight.
    next_cycle(); rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_re", 32'(mem_re), 32'd0);
    next_cycle(); @(negedge clk);
    check_eq("mrst_valid", 32'(out_valid), 32'd0);
    check_eq("mrst_a", mem_a, 32'h0);
    check_eq("mrst_pc", out_pc, 32'h0);
    check_eq("mrst_instr", out_instr, 32'h0);
    check_eq("mrst_misalign", 32'(misalign_err), 32'd0);

    // Restart and apply backpressure from cycle 2 for 6 cycles.
    next_cycle(); rst_n = 1'b1;                                   // c0
    @(negedge clk);
    check_eq("bp_c0_re", 32'(mem_re), 32'd1);
    check_eq("bp_c0_a", mem_a, 32'h0);
    next_cycle(); @(negedge clk);                                 // c1
    check_eq("bp_c1_valid", 32'(out_valid), 32'd0);
    next_cycle(); out_ready = 1'b0;                               // c2
    @(negedge clk);
    check_eq("bp_c2_re", 32'(mem_re), 32'd1);
    for (int i = 3; i < 8; i++) begin                             // c3..c7
      next_cycle(); @(negedge clk);
      check_eq("bp_stall_re", 32'(mem_re), 32'd0);
      check_eq("bp_hold_pc", out_pc, 32'h0);
      check_eq("bp_hold_instr", out_instr, 32'h0);
    end
    next_cycle(); out_ready = 1'b1;                               // c8
    @(negedge clk);
    check_eq("bp_c8_re", 32'(mem_re), 32'd0);
    check_eq("bp_c8_pc", out_pc, 32'h0);
    next_cycle(); @(negedge clk);                                 // c9
    check_eq("bp_c9_pc", out_pc, 32'h4);
    check_eq("bp_c9_re", 32'(mem_re), 32'd1);
    check_eq("bp_c9_a", mem_a, 32'hC);
    next_cycle(); @(negedge clk);                                 // c10
    check_eq("bp_c10_pc", out_pc, 32'h8);
    next_cycle(); @(negedge clk);                                 // c11
    check_eq("bp_c11_pc", out_pc, 32'hC);

    // Stall one cycle to hold two entries, then redirect on a pop, then back-to-back.
    next_cycle(); out_ready = 1'b0;                               // c12
    next_cycle(); out_ready = 1'b1;                               // c13
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    next_cycle(); redirect_pc = 32'h80;                           // c14
    @(negedge clk);
    check_eq("bb_c14_valid", 32'(out_valid), 32'd0);
    next_cycle(); redirect_valid = 1'b0;                          // c15
    @(negedge clk);
    check_eq("bb_c15_re", 32'(mem_re), 32'd1);
    check_eq("bb_c15_a", mem_a, 32'h80);
    check_eq("bb_c15_valid", 32'(out_valid), 32'd0);
    next_cycle(); @(negedge clk);                                 // c16
    check_eq("bb_c16_valid", 32'(out_valid), 32'd0);
    next_cycle(); @(negedge clk);                                 // c17
    check_eq("bb_c17_pc", out_pc, 32'h80);
    check_eq("bb_c17_instr", out_instr, 32'h20);
    repeat (6) next_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction fetch controller that sequences the L1 instruction ROM (synchronous read, 1-cycle latency) and presents instructions to decode over a valid/ready handshake.
- Owns the fetch PC and issues the ROM read-enable and address.
- Tags each response with its PC and buffers it.
- Handles branch/jump redirects by killing in-flight and buffered fetches.
- Sits between the PC/branch logic and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 3, output buffer entries; must be >= 3 for 1 instr/cycle throughput

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
mem_re  output  1  ROM read enable
mem_a  output  32  ROM byte address, always word aligned
mem_rd  input  32  ROM read data, valid the cycle after mem_re
redirect_valid  input  1  redirect request, single-cycle pulse
redirect_pc  input  32  redirect target byte address
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts
out_instr  output  32  instruction word
out_pc  output  32  PC of out_instr
misalign_err  output  1  1-cycle pulse: redirect target not word aligned

Behaviour:
Reset (rst_n=0 at a rising edge):
- fetch_pc=RESET_PC; buffer empty; no fetch in flight; state=RUN.
- mem_re=0, mem_a=RESET_PC, out_valid=0, out_instr=0, out_pc=0, misalign_err=0.
- Reset asserted mid-operation discards everything, including a response arriving the next cycle.

State machine, states RUN and FAULT:
- RUN -> FAULT when redirect_valid=1 and redirect_pc[1:0]!=0. misalign_err=1 the following cycle.
- FAULT -> RUN when redirect_valid=1 and redirect_pc[1:0]==0.
- In FAULT: mem_re=0 and out_valid=0. FAULT stays until an aligned redirect arrives.

Issue rules (RUN only):
- mem_re = (occ + inflight < DEPTH) && !redirect_valid.
- occ = buffer entries; inflight = 0 or 1.
- mem_a = fetch_pc.
- On issue: fetch_pc += 4, wrapping modulo 2^32. The issued PC is latched as the response tag.
- The credit check uses registered counts only; there is no combinational path from out_ready to mem_re.

Response:
- The cycle after an issue, mem_rd and its tag are written into the buffer, unless the fetch was killed.
- A write is always legal because of the credit rule; overflow is impossible and is asserted in simulation.

Output handshake:
- out_valid = !empty. out_instr and out_pc come from the buffer head, registered.
- Pop happens when out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_instr and out_pc must hold stable.
- A simultaneous push and pop is allowed, including when the buffer is full.

Latency:
- Issue at cycle t gives out_valid with that instruction at t+2.
- First instruction after reset release: mem_re=1 in cycle 0 at RESET_PC, out_valid=1 in cycle 2.
- With out_ready held at 1, one instruction per cycle, PCs in sequence.

Redirect (highest priority):
- In the redirect cycle: the buffer is flushed, any in-flight response is killed and dropped when it arrives next cycle, and no issue occurs.
- Any pop in that cycle is ignored.
- fetch_pc=redirect_pc, masked to word alignment only on the aligned path.
- First target fetch issues the cycle after the redirect; its instruction is valid 3 cycles after the redirect.
- Back-to-back redirects: the last one wins; earlier targets are never delivered.

Decomposition:
- Package ifetch_pkg holds:
  - the state enum (RUN, FAULT),
  - INSTR_BYTES=4,
  - the default RESET_PC,
  - the packed entry typedef {pc[31:0], instr[31:0]}.
- One sub-module: fetch_buf. It is a DEPTH-entry synchronous FIFO with flush, push, pop, head output and occupancy count, using wrap-around pointers. Its flush has priority over push and pop.
- Issue logic, tag register, kill flag and FSM stay in ifetch_ctrl.

Test Plan:
1. Release reset with RESET_PC=0 and out_ready=1, ROM word k = k -> mem_re=1 in cycle 0. out_valid rises in cycle 2 and delivers (pc,instr) = (0,0),(4,1),(8,2)... one per cycle with no bubbles.
2. Backpressure: out_ready=0 from cycle 2 for 6 cycles -> occ reaches 3 and mem_re drops to 0. Output holds (0,0) stable. On release, the sequence resumes at pc 4 with no loss or duplication.
3. Redirect to 0x100 in the cycle where a fetch of 0x10 is in flight -> the 0x10 response is dropped and the buffer is empty next cycle. The first delivered pc is 0x100, 3 cycles after the redirect.
4. Redirect to 0x102 -> misalign_err pulses once, mem_re=0 and out_valid=0 for 10 cycles. Then a redirect to 0x200 -> fetching resumes and pc 0x200 is delivered.
5. Redirect in the same cycle as a pop, with 2 entries buffered -> the pop is ignored and nothing stale is delivered. Back-to-back redirects 0x40 then 0x80 -> only 0x80 onward is delivered.
6. rst_n=0 mid-stream while a fetch is in flight -> next cycle all outputs are at reset values. Fetching restarts at RESET_PC with no stale instruction emitted.
